// File: rtl/result_bcd_display_pkg.sv
// Shared constants, state encoding and helpers for the signed-result BCD display block.
package result_bcd_display_pkg;

  localparam int DATA_W      = 7;
  localparam int ITER_CNT    = 7;
  localparam int ADD3_THRESH = 5;
  localparam int BCD_W       = 8;
  localparam int CNT_W       = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef struct packed {
    logic       sign;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ovf;
  } result_t;

  function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
    return (nib >= 4'(ADD3_THRESH)) ? nib + 4'd3 : nib;
  endfunction

  // Negation is done one bit wider so -64 becomes +64 instead of wrapping back to -64.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] z);
    logic [DATA_W:0] ext;
    ext = {z[DATA_W-1], z};
    if (z[DATA_W-1]) ext = '0 - ext;
    return ext[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low seven-segment pattern, segment order gfedcba; non-decimal codes blank.
module bcd_to_seg7 (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/result_bcd_display.sv
// Converts a 7-bit two's-complement result to sign + two BCD digits by double-dabble.
// Define RESULT_SEG7_EN to add registered active-low seven-segment outputs.
module result_bcd_display
  import result_bcd_display_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] Z,
  input  logic              obit,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              sign,
  output logic [3:0]        tens,
  output logic [3:0]        ones,
  output logic              ovf
`ifdef RESULT_SEG7_EN
  ,
  output logic [6:0]        seg_sign,
  output logic [6:0]        seg_tens,
  output logic [6:0]        seg_ones
`endif
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              sign_cap_q, sign_cap_d;
  logic              ovf_cap_q, ovf_cap_d;
  result_t           res_q, res_d;

  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_step;
  logic [DATA_W-1:0] bin_step;
  logic              last_step;

  // One double-dabble step: add-3 correction, then shift the binary MSB into the BCD LSB.
  assign bcd_adj   = {bcd_add3(bcd_q[7:4]), bcd_add3(bcd_q[3:0])};
  assign bcd_step  = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
  assign bin_step  = {bin_q[DATA_W-2:0], 1'b0};
  assign last_step = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(ITER_CNT - 1));

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    sign_cap_d = sign_cap_q;
    ovf_cap_d  = ovf_cap_q;
    res_d      = res_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_cap_d = Z[DATA_W-1];
          ovf_cap_d  = obit;
          bin_d      = magnitude(Z);
          bcd_d      = '0;
          cnt_d      = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bin_d = bin_step;
        bcd_d = bcd_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          res_d   = '{sign: sign_cap_q, tens: bcd_step[7:4], ones: bcd_step[3:0], ovf: ovf_cap_q};
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      sign_cap_q <= 1'b0;
      ovf_cap_q  <= 1'b0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      sign_cap_q <= sign_cap_d;
      ovf_cap_q  <= ovf_cap_d;
      res_q      <= res_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign sign = res_q.sign;
  assign tens = res_q.tens;
  assign ones = res_q.ones;
  assign ovf  = res_q.ovf;

`ifdef RESULT_SEG7_EN
  logic [6:0] seg_tens_new, seg_ones_new;
  logic [6:0] seg_sign_q, seg_sign_d;
  logic [6:0] seg_tens_q, seg_tens_d;
  logic [6:0] seg_ones_q, seg_ones_d;

  bcd_to_seg7 u_seg_tens (.bcd(bcd_step[7:4]), .seg(seg_tens_new));
  bcd_to_seg7 u_seg_ones (.bcd(bcd_step[3:0]), .seg(seg_ones_new));

  // The sign digit reuses the decoder on an out-of-range code to get its blank pattern.
  logic [6:0] seg_blank;
  bcd_to_seg7 u_seg_sign (.bcd(4'hF), .seg(seg_blank));

  always_comb begin
    seg_sign_d = seg_sign_q;
    seg_tens_d = seg_tens_q;
    seg_ones_d = seg_ones_q;
    if (last_step) begin
      seg_sign_d = sign_cap_q ? 7'b0111111 : seg_blank;
      seg_tens_d = seg_tens_new;
      seg_ones_d = seg_ones_new;
    end
  end

  // Reset patterns match the cleared digits: blank sign, "0" in both digit positions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sign_q <= 7'b1111111;
      seg_tens_q <= 7'b1000000;
      seg_ones_q <= 7'b1000000;
    end else begin
      seg_sign_q <= seg_sign_d;
      seg_tens_q <= seg_tens_d;
      seg_ones_q <= seg_ones_d;
    end
  end

  assign seg_sign = seg_sign_q;
  assign seg_tens = seg_tens_q;
  assign seg_ones = seg_ones_q;
`endif

endmodule

// File: tb/tb_result_bcd_display.sv
// Scoreboard bench for result_bcd_display: stimulus pushes expected results, a monitor checks each done.
module tb_result_bcd_display;

  logic       clk;
  logic       rst_n;
  logic [6:0] z;
  logic       obit;
  logic       start;
  logic       busy, done, sign, ovf;
  logic [3:0] tens, ones;
`ifdef RESULT_SEG7_EN
  logic [6:0] seg_sign, seg_tens, seg_ones;
`endif

  result_bcd_display dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Z     (z),
    .obit  (obit),
    .start (start),
    .busy  (busy),
    .done  (done),
    .sign  (sign),
    .tens  (tens),
    .ones  (ones),
    .ovf   (ovf)
`ifdef RESULT_SEG7_EN
    ,
    .seg_sign (seg_sign),
    .seg_tens (seg_tens),
    .seg_ones (seg_ones)
`endif
  );

  typedef struct {
    logic       sign;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ovf;
    int         cap;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

`ifdef RESULT_SEG7_EN
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
`endif

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("latency", cyc - mon_e.cap, 7);
        check("sign", int'(sign), int'(mon_e.sign));
        check("tens", int'(tens), int'(mon_e.tens));
        check("ones", int'(ones), int'(mon_e.ones));
        check("ovf",  int'(ovf),  int'(mon_e.ovf));
`ifdef RESULT_SEG7_EN
        check("seg_sign", int'(seg_sign), mon_e.sign ? 7'b0111111 : 7'b1111111);
        check("seg_tens", int'(seg_tens), int'(seg_of(mon_e.tens)));
        check("seg_ones", int'(seg_ones), int'(seg_of(mon_e.ones)));
`endif
      end
    end
  end

  // Drive one start pulse; optionally push the expected result keyed to the capture edge.
  task automatic issue(input logic [6:0] zv, input logic ob, input logic push,
                       input logic es, input logic [3:0] et, input logic [3:0] eo, input logic eov);
    exp_t e;
    @(negedge clk);
    z = zv; obit = ob; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.sign = es; e.tens = et; e.ones = eo; e.ovf = eov; e.cap = cyc;
      sb_q.push_back(e);
    end
    z = ~zv; obit = ~ob;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  task automatic convert(input logic [6:0] zv, input logic ob,
                         input logic es, input logic [3:0] et, input logic [3:0] eo, input logic eov);
    issue(zv, ob, 1'b1, es, et, eo, eov);
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0; z = '0; obit = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_out",  int'({sign, tens, ones, ovf}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors: Z, obit -> sign, tens, ones, ovf
    convert(7'b0101101, 1'b0, 1'b0, 4'd4, 4'd5, 1'b0);  // +45
    convert(7'b1000000, 1'b0, 1'b1, 4'd6, 4'd4, 1'b0);  // -64
    convert(7'b0000000, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);  // 0, no negative zero
    convert(7'b0111111, 1'b0, 1'b0, 4'd6, 4'd3, 1'b0);  // +63
    convert(7'b1011011, 1'b1, 1'b1, 4'd3, 4'd7, 1'b1);  // -37 with overflow
    convert(7'b1111111, 1'b1, 1'b1, 4'd0, 4'd1, 1'b1);  // -1 with overflow

    // +45 with a second start (Z=+12) on the 3rd SHIFT cycle: ignored, not queued.
    issue(7'b0101101, 1'b0, 1'b1, 1'b0, 4'd4, 4'd5, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_continuous", int'(busy), 1);
      if (i < 7) check("hold_during_shift", int'({sign, tens, ones, ovf}), 10'b1_0000_0001_1);
      if (i == 2) begin z = 7'b0001100; obit = 1'b0; start = 1'b1; end
      if (i == 3) start = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("no_queued_start", int'(busy), 0);

    // +45 aborted by reset on the 4th SHIFT cycle.
    issue(7'b0101101, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_out",  int'({sign, tens, ones, ovf}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_idle", int'(busy), 0);
    check("abort_out_after", int'({sign, tens, ones, ovf}), 0);

    convert(7'b0001001, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0);  // +9
    convert(7'b0001100, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0);  // +12

    repeat (4) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
